aes_core_seq: RTL and testbench
===============================

AES_CORE_SEQ -- requirements
Module: aes_core_seq

Interface
REQ-001 Parameter INIT_CYCLES, default 88: cycles held in INIT after reset release, before the first block is accepted.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before an error completion.
REQ-003 Parameter DONE_CODE, default 8'h10: core_signals value marking the first output word.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 = reset.
REQ-006 in_valid  in  1  a request block is offered.
REQ-007 in_ready  out  1  controller accepts a request this cycle.
REQ-008 in_text  in  128  cipher/plain text block; bits [127:96] are the first word.
REQ-009 in_key  in  128  key for the block.
REQ-010 in_dec  in  1  1 = decrypt, 0 = encrypt.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 out_text  out  128  result block.
REQ-014 out_err  out  1  qualifies out_valid; 1 = timeout, and out_text is then 0.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 core_start  out  1  drives the core start input.
REQ-017 core_data_in  out  32  drives the core data_in input.
REQ-018 core_key_in  out  128  drives the core key_in input.
REQ-019 core_selEncDec  out  1  drives the core selEncDec input.
REQ-020 core_data_out  in  32  core data_out input.
REQ-021 core_signals  in  8  core status input.

Function
REQ-022 The controller SHALL implement states INIT, IDLE, START, LOAD, WAIT, READ and OUT, with 2-bit word index idx and a counter cnt.
REQ-023 INIT: core_start=1; transitions to IDLE after INIT_CYCLES edges.
REQ-024 IDLE: in_ready=1, and it is the only state with in_ready=1; on in_valid=1 the controller latches in_text, in_key and in_dec and moves to START.
REQ-025 core_key_in and core_selEncDec SHALL output the latched values, which stay stable from acceptance until the next acceptance.
REQ-026 START: core_start=1 for exactly 2 cycles, then LOAD with idx=0.
REQ-027 LOAD: core_start=0; core_data_in = latched word idx; words are taken MSW first, one per cycle, 4 cycles total; then WAIT with cnt=0.
REQ-028 core_data_in SHALL be 0 in all states other than LOAD.
REQ-029 WAIT on an edge where core_signals==DONE_CODE: out_text[127:96] <= core_data_out; next state READ with idx=1.
REQ-030 WAIT on an edge where core_signals!=DONE_CODE: cnt increments; when cnt==TIMEOUT the next state is OUT with out_err=1 and out_text=0.
REQ-031 A DONE_CODE match on the same edge that cnt reaches TIMEOUT SHALL win: normal capture occurs, no error.
REQ-032 READ SHALL capture core_data_out into words 1, 2 and 3 on three consecutive edges, ignoring core_signals; then OUT with out_err=0.
REQ-033 OUT: out_valid=1; out_text and out_err are held until out_ready=1, then IDLE.
REQ-034 Input latency: acceptance to the first LOAD word is 3 cycles.
REQ-035 Output latency: the DONE_CODE edge to out_valid is 4 cycles.
REQ-036 in_valid outside IDLE SHALL be ignored, with in_ready=0 and no latch.
REQ-037 Back-to-back operation: an out_ready handshake returns the controller to IDLE, and it accepts again the following cycle.

Reset
REQ-038 While reset=0 the controller SHALL be in INIT with cnt=0, idx=0, core_start=1, in_ready=0, out_valid=0, out_err=0, busy=1, and all data/key outputs and latches at 0.
REQ-039 Reset asserted in any state, mid-operation included, SHALL abort immediately; the partial result is discarded, no out_valid is produced, and the full INIT_CYCLES sequence is repeated.

Verification
REQ-040 Reset release, in_valid held at 1 -> in_ready stays 0 for 88 cycles and is 1 in cycle 89; core_start is 1 throughout INIT.
REQ-041 Decrypt, key 000102030405060708090a0b0c0d0e0f, text 69c4e0d86a7b0430d8cdb78070b4c55a -> core_selEncDec=1, core_start high for 2 cycles, core_data_in 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, core_signals never equal to DONE_CODE before the result; out_text=00112233445566778899aabbccddeeff, out_err=0.
REQ-042 Core model asserts DONE_CODE with words 11111111, 22222222, 33333333, 44444444 -> out_valid exactly 4 cycles later; out_text=11111111222222223333333344444444.
REQ-043 core_signals never equal to DONE_CODE -> out_valid with out_err=1 and out_text=0 after 256 WAIT cycles.
REQ-044 out_ready held 0 for 10 cycles -> out_valid and out_text stable; a second in_valid is not accepted.
REQ-045 reset=0 pulsed during READ -> no out_valid; the controller re-enters INIT and the next block completes correctly.

Source files
------------

// File: rtl/aes_core_seq.sv
// Sequencer that feeds a 32-bit-wide AES core: it latches a 128-bit block and key, streams the
// text in four words, then collects the four result words once the core reports completion.
module aes_core_seq #(
    parameter int         INIT_CYCLES = 88,
    parameter int         TIMEOUT     = 255,
    parameter logic [7:0] DONE_CODE   = 8'h10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    input  logic         in_dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         out_err,
    output logic         busy,
    output logic         core_start,
    output logic [31:0]  core_data_in,
    output logic [127:0] core_key_in,
    output logic         core_selEncDec,
    input  logic [31:0]  core_data_out,
    input  logic [7:0]   core_signals
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    // One counter serves INIT, START and the WAIT timeout, so size it for the largest span.
    localparam int CNT_MAX = (INIT_CYCLES > TIMEOUT) ? INIT_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [127:0]     text_q;
    logic [127:0]     key_q;
    logic             dec_q;
    logic [127:0]     res_q;
    logic             err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_INIT;
            cnt    <= '0;
            idx    <= '0;
            text_q <= '0;
            key_q  <= '0;
            dec_q  <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        text_q <= in_text;
                        key_q  <= in_key;
                        dec_q  <= in_dec;
                        cnt    <= '0;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_LOAD;
                        idx   <= 2'd0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    // A completion on the timeout edge still counts as a normal result.
                    if (core_signals == DONE_CODE) begin
                        res_q[127:96] <= core_data_out;
                        err_q         <= 1'b0;
                        idx           <= 2'd1;
                        state         <= S_READ;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= S_OUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_READ: begin
                    case (idx)
                        2'd1:    res_q[95:64] <= core_data_out;
                        2'd2:    res_q[63:32] <= core_data_out;
                        default: res_q[31:0]  <= core_data_out;
                    endcase
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        core_data_in = '0;
        if (state == S_LOAD) begin
            case (idx)
                2'd0:    core_data_in = text_q[127:96];
                2'd1:    core_data_in = text_q[95:64];
                2'd2:    core_data_in = text_q[63:32];
                default: core_data_in = text_q[31:0];
            endcase
        end
    end

    assign in_ready       = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign out_valid      = (state == S_OUT);
    assign core_start     = (state == S_INIT) || (state == S_START);
    assign out_text       = res_q;
    assign out_err        = err_q;
    assign core_key_in    = key_q;
    assign core_selEncDec = dec_q;

endmodule

// File: tb/tb_aes_core_seq.sv
// Directed bench for aes_core_seq: the bench plays the AES core and checks sequencing,
// latencies, timeout handling, output hold and mid-operation reset.
module tb_aes_core_seq;

    localparam logic [7:0] DONE = 8'h10;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         in_dec;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         out_err;
    logic         busy;
    logic         core_start;
    logic [31:0]  core_data_in;
    logic [127:0] core_key_in;
    logic         core_selEncDec;
    logic [31:0]  core_data_out;
    logic [7:0]   core_signals;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_core_seq dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_text        (in_text),
        .in_key         (in_key),
        .in_dec         (in_dec),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_text       (out_text),
        .out_err        (out_err),
        .busy           (busy),
        .core_start     (core_start),
        .core_data_in   (core_data_in),
        .core_key_in    (core_key_in),
        .core_selEncDec (core_selEncDec),
        .core_data_out  (core_data_out),
        .core_signals   (core_signals)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers one block in IDLE and steps to the first WAIT cycle (acceptance + 2 START + 4 LOAD).
    task automatic send_block(input logic [127:0] t, input logic [127:0] k, input logic d);
        in_text  = t;
        in_key   = k;
        in_dec   = d;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (6) tick;
    endtask

    // Core completion: DONE with word 0, then words 1..3; ends in the OUT cycle.
    task automatic core_reply(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        core_signals  = DONE;
        core_data_out = w0;
        tick;
        core_signals  = 8'h01;
        core_data_out = w1;
        tick;
        core_data_out = w2;
        tick;
        core_data_out = w3;
        tick;
        core_signals  = 8'h00;
        core_data_out = 32'h0;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        in_text  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        in_key   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        in_dec   = 1'b1;
        #2 reset = 1'b0;
        repeat (3) tick;
        total++;
        if ({in_ready, out_valid, out_err, core_start, busy, core_selEncDec} !== 6'b000110) begin
            bad++;
            $display("FAIL rst_ctrl got=%b want=000110",
                     {in_ready, out_valid, out_err, core_start, busy, core_selEncDec});
        end
        total++;
        if (core_data_in !== 32'h0 || core_key_in !== 128'h0 || out_text !== 128'h0) begin
            bad++;
            $display("FAIL rst_data got=%h/%h/%h want=0", core_data_in, core_key_in, out_text);
        end
        reset = 1'b1;
        for (int c = 1; c <= 88; c++) begin
            total++;
            if (in_ready !== 1'b0 || core_start !== 1'b1) begin
                bad++;
                $display("FAIL init_cycle%0d got in_ready=%b core_start=%b want 0/1", c, in_ready, core_start);
            end
            tick;
        end
        total++;
        if (in_ready !== 1'b1 || core_start !== 1'b0) begin
            bad++;
            $display("FAIL init_cycle89 got in_ready=%b core_start=%b want 1/0", in_ready, core_start);
        end
        in_valid = 1'b0;
        total++;
        if (core_key_in !== 128'h0) begin
            bad++;
            $display("FAIL init_no_latch got=%h want=0", core_key_in);
        end
    endtask

    task automatic test_decrypt;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h69c4e0d8; exp_w[1] = 32'h6a7b0430;
        exp_w[2] = 32'hd8cdb780; exp_w[3] = 32'h70b4c55a;
        in_text  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        in_key   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        in_dec   = 1'b1;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (core_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || core_data_in !== 32'h0) begin
                bad++;
                $display("FAIL dec_start%0d got start=%b rdy=%b busy=%b din=%h want 1/0/1/0",
                         s, core_start, in_ready, busy, core_data_in);
            end
            tick;
        end
        total++;
        if (core_selEncDec !== 1'b1 || core_key_in !== 128'h00010203_04050607_08090a0b_0c0d0e0f) begin
            bad++;
            $display("FAIL dec_key got sel=%b key=%h", core_selEncDec, core_key_in);
        end
        for (int w = 0; w < 4; w++) begin
            total++;
            if (core_start !== 1'b0 || core_data_in !== exp_w[w]) begin
                bad++;
                $display("FAIL dec_load%0d got start=%b din=%h want 0/%h", w, core_start, core_data_in, exp_w[w]);
            end
            tick;
        end
        total++;
        if (core_data_in !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL dec_wait got din=%h ov=%b want 0/0", core_data_in, out_valid);
        end
        repeat (5) tick;
        core_reply(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_text !== 128'h00112233_44556677_8899aabb_ccddeeff) begin
            bad++;
            $display("FAIL dec_result got ov=%b err=%b text=%h want 1/0/00112233445566778899aabbccddeeff",
                     out_valid, out_err, out_text);
        end
        handshake;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL dec_return got ov=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_out_latency;
        logic [31:0] w [4];
        w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
        send_block(128'h3243f6a8_885a308d_313198a2_e0370734, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b0);
        repeat (3) tick;
        core_signals  = DONE;
        core_data_out = w[0];
        for (int k = 1; k <= 4; k++) begin
            tick;
            core_signals = 8'h00;
            total++;
            if (out_valid !== (k == 4)) begin
                bad++;
                $display("FAIL lat_cycle%0d got ov=%b want %0d", k, out_valid, (k == 4));
            end
            if (k < 4) core_data_out = w[k];
        end
        core_data_out = 32'h0;
        total++;
        if (out_text !== 128'h11111111_22222222_33333333_44444444 || out_err !== 1'b0 || core_selEncDec !== 1'b0) begin
            bad++;
            $display("FAIL lat_result got text=%h err=%b sel=%b want 11111111222222223333333344444444/0/0",
                     out_text, out_err, core_selEncDec);
        end
    endtask

    task automatic test_hold;
        in_valid = 1'b1;
        in_text  = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
        in_key   = 128'h55555555_66666666_77777777_88888888;
        in_dec   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_text !== 128'h11111111_22222222_33333333_44444444 ||
                core_key_in !== 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c) begin
                bad++;
                $display("FAIL hold_cycle%0d got ov=%b rdy=%b text=%h key=%h", c, out_valid, in_ready, out_text, core_key_in);
            end
            tick;
        end
        in_valid = 1'b0;
        handshake;
        total++;
        if (in_ready !== 1'b1 || core_selEncDec !== 1'b0 ||
            core_key_in !== 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c) begin
            bad++;
            $display("FAIL hold_no_latch got rdy=%b sel=%b key=%h want 1/0/2b7e1516...", in_ready, core_selEncDec, core_key_in);
        end
    endtask

    task automatic test_back_to_back;
        send_block(128'h01010101_02020202_03030303_04040404, 128'hffeeddcc_bbaa9988_77665544_33221100, 1'b1);
        total++;
        if (core_key_in !== 128'hffeeddcc_bbaa9988_77665544_33221100 || core_selEncDec !== 1'b1) begin
            bad++;
            $display("FAIL b2b_key got key=%h sel=%b", core_key_in, core_selEncDec);
        end
        core_reply(32'hcafebabe, 32'h0badf00d, 32'h12345678, 32'h9abcdef0);
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_text !== 128'hcafebabe_0badf00d_12345678_9abcdef0) begin
            bad++;
            $display("FAIL b2b_result got ov=%b err=%b text=%h", out_valid, out_err, out_text);
        end
        handshake;
    endtask

    task automatic test_timeout;
        send_block(128'h1, 128'h2, 1'b0);
        core_signals = 8'h00;
        repeat (255) tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL to_wait255 got ov=%b want 0", out_valid);
        end
        tick;
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_text !== 128'h0) begin
            bad++;
            $display("FAIL to_result got ov=%b err=%b text=%h want 1/1/0", out_valid, out_err, out_text);
        end
        handshake;
    endtask

    task automatic test_done_at_timeout;
        send_block(128'h3, 128'h4, 1'b1);
        core_signals = 8'h00;
        repeat (255) tick;
        core_reply(32'h0a0a0a0a, 32'h0b0b0b0b, 32'h0c0c0c0c, 32'h0d0d0d0d);
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_text !== 128'h0a0a0a0a_0b0b0b0b_0c0c0c0c_0d0d0d0d) begin
            bad++;
            $display("FAIL edge_done got ov=%b err=%b text=%h want 1/0/0a0a0a0a0b0b0b0b0c0c0c0c0d0d0d0d",
                     out_valid, out_err, out_text);
        end
        handshake;
    endtask

    task automatic test_reset_mid;
        send_block(128'h5, 128'h6, 1'b1);
        tick;
        core_signals  = DONE;
        core_data_out = 32'h77777777;
        tick;
        core_signals  = 8'h00;
        core_data_out = 32'h88888888;
        tick;
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || core_start !== 1'b1 || in_ready !== 1'b0 ||
            out_text !== 128'h0 || core_key_in !== 128'h0) begin
            bad++;
            $display("FAIL mid_rst got ov=%b start=%b rdy=%b text=%h key=%h", out_valid, core_start, in_ready, out_text, core_key_in);
        end
        tick;
        reset = 1'b1;
        core_data_out = 32'h0;
        for (int c = 1; c <= 88; c++) begin
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL mid_init%0d got ov=%b rdy=%b want 0/0", c, out_valid, in_ready);
            end
            tick;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_idle got rdy=%b want 1", in_ready);
        end
        send_block(128'h9, 128'ha, 1'b0);
        core_reply(32'hfeedface, 32'hdeadbeef, 32'h00000001, 32'h80000000);
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_text !== 128'hfeedface_deadbeef_00000001_80000000) begin
            bad++;
            $display("FAIL mid_next got ov=%b err=%b text=%h", out_valid, out_err, out_text);
        end
        handshake;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_text       = '0;
        in_key        = '0;
        in_dec        = 1'b0;
        out_ready     = 1'b0;
        core_data_out = '0;
        core_signals  = '0;
        test_reset;
        test_decrypt;
        test_out_latency;
        test_hold;
        test_back_to_back;
        test_timeout;
        test_done_at_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
